uart_receiver: RTL and testbench

//  UART receive engine for the peripheral subsystem. Runs on sysclk and deserialises the UART_RX line (8N1, LSB first).

---
 rtl/uart_receiver.sv | 171 +++++++++++++++++
 tb/tb_uart_receiver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART 8N1 receiver: 2-flop synchroniser, 16x oversampled FSM, FWFT FIFO.
// Ports: sysclk/reset, rx, rd_en, err_clr in; rx_data/rx_valid/count/flags/rx_irq out.
module uart_receiver #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          rx_irq
);

  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic [DW-1:0] r_div;
  state_t        r_state;
  logic [3:0]    r_scnt;
  logic [2:0]    r_bcnt;
  logic [7:0]    r_shreg;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ferr;
  logic          r_ovr;

  logic w_rxs;
  logic w_tick;
  logic w_stop_smp;
  logic w_push;
  logic w_ferr_set;
  logic w_pop;
  logic w_full;
  logic w_wr;
  logic w_ovr_set;

  assign w_rxs      = r_sync2;
  assign w_tick     = (r_div == DIV_LAST);
  assign w_stop_smp = w_tick && (r_state == S_STOP) && (r_scnt == 4'd15);
  assign w_push     = w_stop_smp & w_rxs;
  assign w_ferr_set = w_stop_smp & ~w_rxs;
  assign w_pop      = rd_en & (r_count != '0);
  assign w_full     = (r_count == FULL);
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_wr       = w_push & (~w_full | w_pop);
  assign w_ovr_set  = w_push & w_full & ~w_pop;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) r_div <= '0;
    else if (w_tick) r_div <= '0;
    else r_div <= r_div + 1'b1;
  end

  // scnt free-runs on every tick; states only clear it where needed
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_scnt  <= '0;
      r_bcnt  <= '0;
      r_shreg <= '0;
    end else if (w_tick) begin
      r_scnt <= r_scnt + 4'd1;
      unique case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            r_scnt  <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_scnt == 4'd7) begin
            if (w_rxs) begin
              r_state <= S_IDLE;
            end else begin
              r_scnt  <= '0;
              r_bcnt  <= '0;
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (r_scnt == 4'd15) begin
            r_shreg <= {w_rxs, r_shreg[7:1]};
            if (r_bcnt == 3'd7) r_state <= S_STOP;
            else r_bcnt <= r_bcnt + 3'd1;
          end
        end
        S_STOP: begin
          if (r_scnt == 4'd15) begin
            r_state <= w_rxs ? S_IDLE : S_BREAK;
          end
        end
        S_BREAK: begin
          if (w_rxs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= r_shreg;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_pop) r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // a set in the same cycle as err_clr wins
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_ferr_set) r_ferr <= 1'b1;
      else if (err_clr) r_ferr <= 1'b0;
      if (w_ovr_set) r_ovr <= 1'b1;
      else if (err_clr) r_ovr <= 1'b0;
    end
  end

  assign rx_data   = r_mem[r_rptr];
  assign rx_valid  = (r_count != '0);
  assign count     = r_count;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign rx_irq    = rx_valid | r_ferr | r_ovr;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver.
// Scaled clock/baud keep each bit at 160 sysclk cycles.
module tb_uart_receiver;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 10000;
  localparam int DEPTH  = 4;
  localparam int BIT    = CLK_HZ / BAUD;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b0;
  logic       rx     = 1'b1;
  logic       rd_en  = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] count;
  logic       frame_err;
  logic       overrun;
  logic       rx_irq;

  uart_receiver #(
    .CLK_HZ(CLK_HZ),
    .BAUD(BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .sysclk(sysclk),
    .reset(reset),
    .rx(rx),
    .rd_en(rd_en),
    .err_clr(err_clr),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .count(count),
    .frame_err(frame_err),
    .overrun(overrun),
    .rx_irq(rx_irq)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [2:0] exp_cnt;
    logic       exp_ferr;
  } vec_t;

  int         ncmp = 0;
  int         nerr = 0;
  logic [7:0] q[$];
  logic       m_ovr = 1'b0;
  vec_t       vecs[6];
  int         n;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge sysclk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      cyc(BIT);
    end
    rx = stop;
    cyc(BIT);
    rx = 1'b1;
  endtask

  task automatic mpush(input logic [7:0] d);
    if (q.size() < DEPTH) q.push_back(d);
    else m_ovr = 1'b1;
  endtask

  task automatic pop_chk(input string nm);
    logic [7:0] e;
    if (q.size() == 0) begin
      ncmp++;
      nerr++;
      $display("FAIL %s: scoreboard empty, got %0h want none", nm, rx_data);
    end else begin
      e = q.pop_front();
      chk({nm, "_valid"}, rx_valid, 1);
      chk({nm, "_data"}, rx_data, e);
    end
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    m_ovr = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vecs[0] = '{8'h55, 1'b1, 3'd1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 3'd1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 3'd1, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 3'd1, 1'b0};
    vecs[4] = '{8'hA5, 1'b0, 3'd0, 1'b1};
    vecs[5] = '{8'h01, 1'b1, 3'd1, 1'b0};

    cyc(5);
    chk("rst_valid", rx_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_irq", rx_irq, 0);
    reset = 1'b1;
    cyc(2 * BIT);

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].data, vecs[i].stop);
      if (vecs[i].stop) mpush(vecs[i].data);
      cyc(BIT);
      chk($sformatf("v%0d_count", i), count, vecs[i].exp_cnt);
      chk($sformatf("v%0d_ferr", i), frame_err, vecs[i].exp_ferr);
      chk($sformatf("v%0d_irq", i), rx_irq, 1);
      if (vecs[i].stop) begin
        pop_chk($sformatf("v%0d_pop", i));
        chk($sformatf("v%0d_cnt0", i), count, 0);
        chk($sformatf("v%0d_vld0", i), rx_valid, 0);
      end else begin
        clr_err();
        chk($sformatf("v%0d_ferr_clr", i), frame_err, 0);
        chk($sformatf("v%0d_irq_clr", i), rx_irq, 0);
      end
    end

    // glitch shorter than half a bit
    rx = 1'b0;
    cyc(50);
    rx = 1'b1;
    cyc(2 * BIT);
    chk("glitch_count", count, 0);
    chk("glitch_ferr", frame_err, 0);
    send(8'h96, 1'b1);
    mpush(8'h96);
    cyc(BIT);
    chk("glitch_after_cnt", count, 1);
    pop_chk("glitch_after");

    // overrun with back-to-back frames
    for (int b = 1; b <= 5; b++) begin
      send(8'(b), 1'b1);
      mpush(8'(b));
    end
    cyc(BIT);
    chk("ovr_count", count, 4);
    chk("ovr_flag", overrun, m_ovr);
    for (int k = 0; k < 4; k++) pop_chk($sformatf("ovr_pop%0d", k));
    chk("ovr_empty", rx_valid, 0);
    clr_err();
    chk("ovr_clr", overrun, 0);

    // push and pop in the same cycle while full
    for (int b = 1; b <= 4; b++) begin
      send(8'(b * 8'h11), 1'b1);
      mpush(8'(b * 8'h11));
    end
    cyc(BIT);
    chk("sim_full", count, 4);
    fork
      send(8'h5A, 1'b1);
      begin
        n = 0;
        while (dut.w_push !== 1'b1 && n < 20 * BIT) begin
          cyc(1);
          n++;
        end
        if (n >= 20 * BIT) begin
          ncmp++;
          nerr++;
          $display("FAIL sim_wait: got no push want push");
        end else begin
          chk("sim_head", rx_data, q.pop_front());
          rd_en = 1'b1;
          cyc(1);
          rd_en = 1'b0;
        end
      end
    join
    q.push_back(8'h5A);
    cyc(BIT);
    chk("sim_ovr", overrun, 0);
    chk("sim_count", count, 4);
    for (int k = 0; k < 4; k++) pop_chk($sformatf("sim_pop%0d", k));
    chk("sim_empty", rx_valid, 0);

    // reset in the middle of bit 3 of 0xF0
    fork
      send(8'hF0, 1'b1);
      begin
        cyc(4 * BIT + BIT / 2);
        reset = 1'b0;
        cyc(5);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_irq", rx_irq, 0);
        cyc(BIT / 2 + 5);
        reset = 1'b1;
      end
    join
    q.delete();
    cyc(BIT);
    chk("post_rst_count", count, 0);
    send(8'h3C, 1'b1);
    mpush(8'h3C);
    cyc(BIT);
    chk("rst_3c_count", count, 1);
    pop_chk("rst_3c");
    chk("rst_3c_empty", rx_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
